id_dual_issue_ctrl: RTL and testbench
=====================================

Name: id_dual_issue_ctrl

Overview:
- Consumer end of the IF/ID instruction queue; sits between the queue head pair and the ID/EXE boundary.
- Each cycle it decides whether to launch two, one or zero instructions, and drives the one-hot launch flags that advance the queue tail.
- It latches launched lanes into a registered two-lane ID/EXE stage.
- It keeps a load-destination scoreboard for load-use stalls.

Parameters:
- LANE_W, 64, payload bits per lane carried to EXE.
- RF_AW, 5, register-address width; address 0 is hardwired zero and never hazards.
- CNT_W, 32, width of the zero-launch stall counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-high reset (asserted = 1).
- line1_now_valid_i  in  1  queue slot 1 (older) valid.
- line2_now_valid_i  in  1  queue slot 2 (younger) valid.
- lineN_payload_i  in  LANE_W  lane payload, N=1,2.
- lineN_rd_i  in  RF_AW  destination register, N=1,2.
- lineN_rd_we_i  in  1  lane writes rd, N=1,2.
- lineN_rs1_i, lineN_rs2_i  in  RF_AW  sources, N=1,2.
- lineN_rs1_use_i, lineN_rs2_use_i  in  1  source actually read, N=1,2.
- lineN_is_load_i  in  1  lane is a load, N=1,2.
- lineN_solo_i  in  1  branch/CSR/barrier; must launch alone, N=1,2.
- next_allowin_i  in  1  EXE accepts new lanes this cycle.
- branch_flush_i  in  1  flush.
- excep_flush_i  in  1  flush.
- double_valid_inst_lunch_flag_o  out  1  two lanes launched this cycle.
- single_valid_inst_lunch_flag_o  out  1  lane 1 only launched.
- zero_valid_inst_lunch_flag_o  out  1  nothing launched.
- exe_line1_valid_o  out  1  registered EXE lane 1 valid.
- exe_line2_valid_o  out  1  registered EXE lane 2 valid.
- exe_line1_payload_o, exe_line2_payload_o  out  LANE_W  registered payloads.
- zero_lunch_cnt_o  out  CNT_W  count of cycles with line1 valid and zero launch.

Behaviour:
- Launch flags are combinational, in the same cycle as the queue outputs, and always exactly one-hot.
- Queue tail updates from the flags on the next edge.
- flush = branch_flush_i | excep_flush_i. While flush = 1: zero = 1, no launch, no counter increment.
- Lane-1 ok condition, all of the following must hold:
  - line1_now_valid_i = 1 and next_allowin_i = 1;
  - no load-use hit: any used source of lane 1, nonzero, equal to a valid scoreboard entry.
- Lane-2 ok condition, all of the following must hold:
  - lane-1 ok, line2_now_valid_i = 1, line1_solo_i = 0 and line2_solo_i = 0;
  - no intra-pair RAW: line1_rd_we_i with nonzero line1_rd_i equal to a used lane-2 source;
  - no intra-pair WAW on the same nonzero rd;
  - no load-use hit for lane 2.
- Flag selection: double = lane-2 ok; single = lane-1 ok & !lane-2 ok; zero = otherwise.
- Lane 2 never launches without lane 1.
- Solo handling: a solo instruction in slot 2 waits until it reaches slot 1, then launches single.
- Scoreboard: two entries {valid, rd}. Loaded on an edge where next_allowin_i = 1:
  - entry N = lineN launched & lineN_is_load_i & lineN_rd_we_i & rd != 0;
  - with next_allowin_i = 1 and zero launch, both entries clear (a bubble enters EXE);
  - with next_allowin_i = 0, entries hold.
- EXE registers (posedge clk):
  - if flush: both valids become 0;
  - else if next_allowin_i: exe_lineN_valid_o becomes lineN launched, and payloads load when launched;
  - else hold.
- Counter: increments, wrap-around, when line1_now_valid_i & zero & !flush.
- Reset (asynchronous, rst_n = 1) and flush both clear: exe valids, scoreboard, and payloads to 0. Reset also clears the counter; flush does not.
- Reset values: exe valids 0, payloads 0, counter 0. Flags reflect inputs, so zero = 1 with an empty queue.
- Mid-operation reset: lanes latched in EXE are dropped and no flag is required to be held.
- Boundaries:
  - both line valids 0 → zero, counter unchanged;
  - line2 valid with line1 invalid → zero; the queue never presents this, but it must be tolerated.

Decomposition:
- Shared package gets the RF_AW and LANE_W defaults and the lane-bus bit-field offsets (rd, rs1, rs2, flag bit positions) alongside the existing IF/ID bus width constants.
- One natural sub-module: id_hazard_check. It is purely combinational and instantiated once per lane. It takes the lane sources/uses plus the scoreboard and an older-lane rd/we, and returns hazard.

Test Plan:
- Both valid, independent (lane1 add r3←r1, lane2 add r4←r2), next_allowin = 1 → double = 1; next cycle exe_line1_valid_o = exe_line2_valid_o = 1.
- Lane2 reads r3 written by lane1 → single = 1; next cycle only exe_line1_valid_o = 1; when lane2 reaches slot 1 it launches.
- Load r5 launched, then slot1 reads r5 → zero = 1 for one cycle, zero_lunch_cnt_o increments by 1; bubble clears the scoreboard and the next cycle gives single/double.
- line1_solo_i = 1 with both valid → single; line2_solo_i = 1 → single, solo launched alone the following cycle.
- next_allowin_i = 0 for 3 cycles with both valid → zero each cycle, EXE registers and scoreboard hold, counter +3.
- excep_flush_i pulse while EXE holds two lanes → zero in that cycle, both exe valids 0 after the edge, scoreboard empty; asynchronous reset mid-burst clears everything including the counter.

Source files
------------

// File: rtl/id_dual_issue_ctrl_pkg.sv
// id_dual_issue_ctrl_pkg
// Purpose : shared constants and types for the ID-stage dual-issue controller.
//           Holds the lane widths, the IF/ID queue bus layout and the launch
//           decision encoding.
// Ports   : none (package).
package id_dual_issue_ctrl_pkg;

  // Default lane geometry.
  localparam int LANE_W_DEF = 64;
  localparam int RF_AW_DEF  = 5;
  localparam int CNT_W_DEF  = 32;

  // Bit-field offsets of one lane inside the IF/ID queue bus
  // (LSB first: flags, then rs2, rs1, rd, then payload on top).
  localparam int FLD_SOLO        = 0;
  localparam int FLD_IS_LOAD     = 1;
  localparam int FLD_RS2_USE     = 2;
  localparam int FLD_RS1_USE     = 3;
  localparam int FLD_RD_WE       = 4;
  localparam int FLD_RS2_LSB     = 5;
  localparam int FLD_RS1_LSB     = FLD_RS2_LSB + RF_AW_DEF;
  localparam int FLD_RD_LSB      = FLD_RS1_LSB + RF_AW_DEF;
  localparam int FLD_PAYLOAD_LSB = FLD_RD_LSB + RF_AW_DEF;

  // IF/ID bus widths: one lane, and the full two-slot head including valids.
  localparam int IF_ID_LANE_BUS_W = FLD_PAYLOAD_LSB + LANE_W_DEF;
  localparam int IF_ID_BUS_W      = 2 * (1 + IF_ID_LANE_BUS_W);

  // Per-cycle launch decision; decoded into the one-hot launch flags.
  typedef enum logic [1:0] {
    LAUNCH_ZERO   = 2'd0,
    LAUNCH_SINGLE = 2'd1,
    LAUNCH_DOUBLE = 2'd2
  } launch_e;

endpackage

// File: rtl/id_dual_issue_ctrl_if.sv
// id_dual_issue_ctrl_if
// Purpose : bundles the IF/ID queue head pair, the EXE handshake, the flush
//           inputs and the launch / EXE-stage outputs of the controller.
// Modports: master - queue/pipeline side (drives lane inputs, reads results)
//           slave  - the controller itself
interface id_dual_issue_ctrl_if
  import id_dual_issue_ctrl_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF,
  parameter int RF_AW  = RF_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  // queue head, slot 1 (older)
  logic              line1_now_valid_i;
  logic [LANE_W-1:0] line1_payload_i;
  logic [RF_AW-1:0]  line1_rd_i;
  logic              line1_rd_we_i;
  logic [RF_AW-1:0]  line1_rs1_i;
  logic [RF_AW-1:0]  line1_rs2_i;
  logic              line1_rs1_use_i;
  logic              line1_rs2_use_i;
  logic              line1_is_load_i;
  logic              line1_solo_i;

  // queue head, slot 2 (younger)
  logic              line2_now_valid_i;
  logic [LANE_W-1:0] line2_payload_i;
  logic [RF_AW-1:0]  line2_rd_i;
  logic              line2_rd_we_i;
  logic [RF_AW-1:0]  line2_rs1_i;
  logic [RF_AW-1:0]  line2_rs2_i;
  logic              line2_rs1_use_i;
  logic              line2_rs2_use_i;
  logic              line2_is_load_i;
  logic              line2_solo_i;

  // pipeline control
  logic              next_allowin_i;
  logic              branch_flush_i;
  logic              excep_flush_i;

  // results
  logic              double_valid_inst_lunch_flag_o;
  logic              single_valid_inst_lunch_flag_o;
  logic              zero_valid_inst_lunch_flag_o;
  logic              exe_line1_valid_o;
  logic              exe_line2_valid_o;
  logic [LANE_W-1:0] exe_line1_payload_o;
  logic [LANE_W-1:0] exe_line2_payload_o;
  logic [CNT_W-1:0]  zero_lunch_cnt_o;

  modport master (
    output line1_now_valid_i, line1_payload_i, line1_rd_i, line1_rd_we_i,
           line1_rs1_i, line1_rs2_i, line1_rs1_use_i, line1_rs2_use_i,
           line1_is_load_i, line1_solo_i,
           line2_now_valid_i, line2_payload_i, line2_rd_i, line2_rd_we_i,
           line2_rs1_i, line2_rs2_i, line2_rs1_use_i, line2_rs2_use_i,
           line2_is_load_i, line2_solo_i,
           next_allowin_i, branch_flush_i, excep_flush_i,
    input  double_valid_inst_lunch_flag_o, single_valid_inst_lunch_flag_o,
           zero_valid_inst_lunch_flag_o, exe_line1_valid_o, exe_line2_valid_o,
           exe_line1_payload_o, exe_line2_payload_o, zero_lunch_cnt_o
  );

  modport slave (
    input  line1_now_valid_i, line1_payload_i, line1_rd_i, line1_rd_we_i,
           line1_rs1_i, line1_rs2_i, line1_rs1_use_i, line1_rs2_use_i,
           line1_is_load_i, line1_solo_i,
           line2_now_valid_i, line2_payload_i, line2_rd_i, line2_rd_we_i,
           line2_rs1_i, line2_rs2_i, line2_rs1_use_i, line2_rs2_use_i,
           line2_is_load_i, line2_solo_i,
           next_allowin_i, branch_flush_i, excep_flush_i,
    output double_valid_inst_lunch_flag_o, single_valid_inst_lunch_flag_o,
           zero_valid_inst_lunch_flag_o, exe_line1_valid_o, exe_line2_valid_o,
           exe_line1_payload_o, exe_line2_payload_o, zero_lunch_cnt_o
  );

endinterface

// File: rtl/id_dual_issue_ctrl_hazard.sv
// id_hazard_check
// Purpose : combinational hazard detector for one lane. Flags a load-use hit
//           against the two-entry load scoreboard, and a RAW or WAW conflict
//           against an older lane issuing in the same cycle.
// Ports   : rs1/rs2, rs1_use/rs2_use - lane sources and whether they are read
//           rd, rd_we                 - lane destination (for WAW)
//           sb_valid, sb_rd0, sb_rd1  - load scoreboard entries
//           older_rd, older_we        - destination of the older co-issued lane
//           hazard                    - lane must not launch this cycle
module id_hazard_check #(
  parameter int RF_AW = 5
) (
  input  logic [RF_AW-1:0] rs1,
  input  logic [RF_AW-1:0] rs2,
  input  logic             rs1_use,
  input  logic             rs2_use,
  input  logic [RF_AW-1:0] rd,
  input  logic             rd_we,
  input  logic [1:0]       sb_valid,
  input  logic [RF_AW-1:0] sb_rd0,
  input  logic [RF_AW-1:0] sb_rd1,
  input  logic [RF_AW-1:0] older_rd,
  input  logic             older_we,
  output logic             hazard
);

  logic rs1_live;
  logic rs2_live;
  logic older_live;
  logic hit_sb0;
  logic hit_sb1;
  logic raw;
  logic waw;

  // Register 0 is hardwired zero, so it never carries a dependency.
  assign rs1_live   = rs1_use && (rs1 != '0);
  assign rs2_live   = rs2_use && (rs2 != '0);
  assign older_live = older_we && (older_rd != '0);

  assign hit_sb0 = sb_valid[0] &&
                   ((rs1_live && (rs1 == sb_rd0)) || (rs2_live && (rs2 == sb_rd0)));
  assign hit_sb1 = sb_valid[1] &&
                   ((rs1_live && (rs1 == sb_rd1)) || (rs2_live && (rs2 == sb_rd1)));

  assign raw = older_live &&
               ((rs1_live && (rs1 == older_rd)) || (rs2_live && (rs2 == older_rd)));
  assign waw = older_live && rd_we && (rd == older_rd);

  assign hazard = hit_sb0 || hit_sb1 || raw || waw;

endmodule

// File: rtl/id_dual_issue_ctrl.sv
// id_dual_issue_ctrl
// Purpose : consumer end of the IF/ID queue. Decides each cycle whether to
//           launch two, one or zero instructions, drives the one-hot launch
//           flags that advance the queue tail, registers the launched lanes
//           into the ID/EXE stage and tracks in-flight loads for load-use
//           stalls. Also counts cycles where slot 1 held an instruction but
//           nothing launched.
// Ports   : clk   - clock
//           rst_n - asynchronous reset, active high despite its name
//           bus   - id_dual_issue_ctrl_if slave modport (queue head, EXE
//                   handshake, flushes, launch flags, EXE stage, counter)
module id_dual_issue_ctrl
  import id_dual_issue_ctrl_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF,
  parameter int RF_AW  = RF_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  id_dual_issue_ctrl_if.slave  bus
);

  logic              flush;
  logic              haz1;
  logic              haz2;
  logic              lane1_ok;
  logic              lane2_ok;
  launch_e           launch;

  logic [1:0]        sb_valid;
  logic [RF_AW-1:0]  sb_rd0;
  logic [RF_AW-1:0]  sb_rd1;

  logic              exe_v1;
  logic              exe_v2;
  logic [LANE_W-1:0] exe_p1;
  logic [LANE_W-1:0] exe_p2;
  logic [CNT_W-1:0]  zero_cnt;

  assign flush = bus.branch_flush_i | bus.excep_flush_i;

  // Lane 1 has no older co-issued lane, so only the scoreboard can stop it.
  id_hazard_check #(.RF_AW(RF_AW)) u_haz_lane1 (
    .rs1      (bus.line1_rs1_i),
    .rs2      (bus.line1_rs2_i),
    .rs1_use  (bus.line1_rs1_use_i),
    .rs2_use  (bus.line1_rs2_use_i),
    .rd       (bus.line1_rd_i),
    .rd_we    (bus.line1_rd_we_i),
    .sb_valid (sb_valid),
    .sb_rd0   (sb_rd0),
    .sb_rd1   (sb_rd1),
    .older_rd ('0),
    .older_we (1'b0),
    .hazard   (haz1)
  );

  id_hazard_check #(.RF_AW(RF_AW)) u_haz_lane2 (
    .rs1      (bus.line2_rs1_i),
    .rs2      (bus.line2_rs2_i),
    .rs1_use  (bus.line2_rs1_use_i),
    .rs2_use  (bus.line2_rs2_use_i),
    .rd       (bus.line2_rd_i),
    .rd_we    (bus.line2_rd_we_i),
    .sb_valid (sb_valid),
    .sb_rd0   (sb_rd0),
    .sb_rd1   (sb_rd1),
    .older_rd (bus.line1_rd_i),
    .older_we (bus.line1_rd_we_i),
    .hazard   (haz2)
  );

  // Lane 2 is gated by lane 1, so a younger instruction can never overtake
  // an older one; a solo instruction in slot 2 simply waits for slot 1.
  assign lane1_ok = !flush && bus.line1_now_valid_i && bus.next_allowin_i && !haz1;
  assign lane2_ok = lane1_ok && bus.line2_now_valid_i &&
                    !bus.line1_solo_i && !bus.line2_solo_i && !haz2;

  always_comb begin
    launch = LAUNCH_ZERO;
    if (lane2_ok) begin
      launch = LAUNCH_DOUBLE;
    end else if (lane1_ok) begin
      launch = LAUNCH_SINGLE;
    end
  end

  assign bus.double_valid_inst_lunch_flag_o = (launch == LAUNCH_DOUBLE);
  assign bus.single_valid_inst_lunch_flag_o = (launch == LAUNCH_SINGLE);
  assign bus.zero_valid_inst_lunch_flag_o   = (launch == LAUNCH_ZERO);

  // ID/EXE stage and load scoreboard. Both advance only when EXE accepts; a
  // zero-launch accepted cycle is a bubble, which empties the scoreboard
  // because nothing launched can be a load.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      exe_v1   <= 1'b0;
      exe_v2   <= 1'b0;
      exe_p1   <= '0;
      exe_p2   <= '0;
      sb_valid <= 2'b00;
      sb_rd0   <= '0;
      sb_rd1   <= '0;
    end else if (flush) begin
      exe_v1   <= 1'b0;
      exe_v2   <= 1'b0;
      exe_p1   <= '0;
      exe_p2   <= '0;
      sb_valid <= 2'b00;
      sb_rd0   <= '0;
      sb_rd1   <= '0;
    end else if (bus.next_allowin_i) begin
      exe_v1 <= lane1_ok;
      exe_v2 <= lane2_ok;
      if (lane1_ok) begin
        exe_p1 <= bus.line1_payload_i;
      end
      if (lane2_ok) begin
        exe_p2 <= bus.line2_payload_i;
      end
      sb_valid[0] <= lane1_ok && bus.line1_is_load_i && bus.line1_rd_we_i &&
                     (bus.line1_rd_i != '0);
      sb_valid[1] <= lane2_ok && bus.line2_is_load_i && bus.line2_rd_we_i &&
                     (bus.line2_rd_i != '0);
      sb_rd0 <= bus.line1_rd_i;
      sb_rd1 <= bus.line2_rd_i;
    end
  end

  // Stall counter: cycles where slot 1 was occupied but nothing left, not
  // counting flush cycles. Wraps silently.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      zero_cnt <= '0;
    end else if (bus.line1_now_valid_i && (launch == LAUNCH_ZERO) && !flush) begin
      zero_cnt <= zero_cnt + 1'b1;
    end
  end

  assign bus.exe_line1_valid_o   = exe_v1;
  assign bus.exe_line2_valid_o   = exe_v2;
  assign bus.exe_line1_payload_o = exe_p1;
  assign bus.exe_line2_payload_o = exe_p2;
  assign bus.zero_lunch_cnt_o    = zero_cnt;

endmodule

// File: tb/tb_id_dual_issue_ctrl.sv
// tb_id_dual_issue_ctrl
// Purpose : directed self-checking bench for id_dual_issue_ctrl. Each task
//           drives one scenario and compares flags, EXE stage and the stall
//           counter against hand-computed values.
module tb_id_dual_issue_ctrl;

  localparam logic [2:0] F_DBL = 3'b100;
  localparam logic [2:0] F_SGL = 3'b010;
  localparam logic [2:0] F_ZRO = 3'b001;

  logic clk;
  logic rst_n;

  int          n_checks;
  int          n_fails;
  logic [31:0] exp_cnt;

  id_dual_issue_ctrl_if #(.LANE_W(64), .RF_AW(5), .CNT_W(32)) bus ();

  id_dual_issue_ctrl #(.LANE_W(64), .RF_AW(5), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  wire [2:0] flags = {bus.double_valid_inst_lunch_flag_o,
                      bus.single_valid_inst_lunch_flag_o,
                      bus.zero_valid_inst_lunch_flag_o};
  wire [1:0] exe_v = {bus.exe_line1_valid_o, bus.exe_line2_valid_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; results are read from there
  // on, well clear of the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane1(input logic v, input logic [4:0] rd, input logic we,
                           input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2,
                           input logic ld, input logic solo, input logic [63:0] pl);
    bus.line1_now_valid_i = v;   bus.line1_rd_i      = rd;  bus.line1_rd_we_i   = we;
    bus.line1_rs1_i       = rs1; bus.line1_rs1_use_i = u1;
    bus.line1_rs2_i       = rs2; bus.line1_rs2_use_i = u2;
    bus.line1_is_load_i   = ld;  bus.line1_solo_i    = solo; bus.line1_payload_i = pl;
  endtask

  task automatic set_lane2(input logic v, input logic [4:0] rd, input logic we,
                           input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2,
                           input logic ld, input logic solo, input logic [63:0] pl);
    bus.line2_now_valid_i = v;   bus.line2_rd_i      = rd;  bus.line2_rd_we_i   = we;
    bus.line2_rs1_i       = rs1; bus.line2_rs1_use_i = u1;
    bus.line2_rs2_i       = rs2; bus.line2_rs2_use_i = u2;
    bus.line2_is_load_i   = ld;  bus.line2_solo_i    = solo; bus.line2_payload_i = pl;
  endtask

  task automatic clear_queue();
    set_lane1(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0);
    set_lane2(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    clear_queue();
    bus.next_allowin_i = 1'b1;
    bus.branch_flush_i = 1'b0;
    bus.excep_flush_i  = 1'b0;
    #3;
    n_checks++; if (exe_v !== 2'b00) begin n_fails++; $display("[TB] FAIL reset_exe_valid: got %b want 00", exe_v); end
    n_checks++; if (bus.exe_line1_payload_o !== 64'h0) begin n_fails++; $display("[TB] FAIL reset_payload1: got %h want 0", bus.exe_line1_payload_o); end
    n_checks++; if (bus.zero_lunch_cnt_o !== 32'd0) begin n_fails++; $display("[TB] FAIL reset_cnt: got %0d want 0", bus.zero_lunch_cnt_o); end
    n_checks++; if (flags !== F_ZRO) begin n_fails++; $display("[TB] FAIL reset_flags: got %b want %b", flags, F_ZRO); end
    step();
    rst_n = 1'b0;
    exp_cnt = 32'd0;
  endtask

  task automatic test_double();
    set_lane1(1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'hA1);
    set_lane2(1'b1, 5'd4, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'hA2);
    #1;
    n_checks++; if (flags !== F_DBL) begin n_fails++; $display("[TB] FAIL double_flags: got %b want %b", flags, F_DBL); end
    step();
    n_checks++; if (exe_v !== 2'b11) begin n_fails++; $display("[TB] FAIL double_exe_valid: got %b want 11", exe_v); end
    n_checks++; if (bus.exe_line1_payload_o !== 64'hA1) begin n_fails++; $display("[TB] FAIL double_payload1: got %h want a1", bus.exe_line1_payload_o); end
    n_checks++; if (bus.exe_line2_payload_o !== 64'hA2) begin n_fails++; $display("[TB] FAIL double_payload2: got %h want a2", bus.exe_line2_payload_o); end
    clear_queue();
    #1;
    n_checks++; if (flags !== F_ZRO) begin n_fails++; $display("[TB] FAIL empty_flags: got %b want %b", flags, F_ZRO); end
    step();
    n_checks++; if (exe_v !== 2'b00) begin n_fails++; $display("[TB] FAIL bubble_exe_valid: got %b want 00", exe_v); end
    n_checks++; if (bus.exe_line1_payload_o !== 64'hA1) begin n_fails++; $display("[TB] FAIL bubble_payload_hold: got %h want a1", bus.exe_line1_payload_o); end
    n_checks++; if (bus.zero_lunch_cnt_o !== exp_cnt) begin n_fails++; $display("[TB] FAIL empty_cnt: got %0d want %0d", bus.zero_lunch_cnt_o, exp_cnt); end
  endtask

  task automatic test_raw_waw();
    set_lane1(1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'hB1);
    set_lane2(1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'hB2);
    #1;
    n_checks++; if (flags !== F_SGL) begin n_fails++; $display("[TB] FAIL raw_flags: got %b want %b", flags, F_SGL); end
    step();
    n_checks++; if (exe_v !== 2'b10) begin n_fails++; $display("[TB] FAIL raw_exe_valid: got %b want 10", exe_v); end
    n_checks++; if (bus.exe_line1_payload_o !== 64'hB1) begin n_fails++; $display("[TB] FAIL raw_payload1: got %h want b1", bus.exe_line1_payload_o); end
    set_lane1(1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'hB2);
    set_lane2(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0);
    #1;
    n_checks++; if (flags !== F_SGL) begin n_fails++; $display("[TB] FAIL raw_shift_flags: got %b want %b", flags, F_SGL); end
    step();
    n_checks++; if (bus.exe_line1_payload_o !== 64'hB2) begin n_fails++; $display("[TB] FAIL raw_shift_payload1: got %h want b2", bus.exe_line1_payload_o); end
    // WAW on r6
    set_lane1(1'b1, 5'd6, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'hB3);
    set_lane2(1'b1, 5'd6, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'hB4);
    #1;
    n_checks++; if (flags !== F_SGL) begin n_fails++; $display("[TB] FAIL waw_flags: got %b want %b", flags, F_SGL); end
    // r0 never creates a dependency
    set_lane1(1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'hB5);
    set_lane2(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 64'hB6);
    #1;
    n_checks++; if (flags !== F_DBL) begin n_fails++; $display("[TB] FAIL r0_flags: got %b want %b", flags, F_DBL); end
    // matching source that is not actually read
    set_lane1(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'hB7);
    set_lane2(1'b1, 5'd8, 1'b1, 5'd7, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 64'hB8);
    #1;
    n_checks++; if (flags !== F_DBL) begin n_fails++; $display("[TB] FAIL unused_src_flags: got %b want %b", flags, F_DBL); end
    clear_queue();
    step();
  endtask

  task automatic test_load_use();
    set_lane1(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 64'hC1);
    #1;
    n_checks++; if (flags !== F_SGL) begin n_fails++; $display("[TB] FAIL load_launch_flags: got %b want %b", flags, F_SGL); end
    step();
    set_lane1(1'b1, 5'd8, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'hC2);
    set_lane2(1'b1, 5'd9, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'hC3);
    #1;
    n_checks++; if (flags !== F_ZRO) begin n_fails++; $display("[TB] FAIL load_use_flags: got %b want %b", flags, F_ZRO); end
    step();
    exp_cnt = exp_cnt + 32'd1;
    n_checks++; if (bus.zero_lunch_cnt_o !== exp_cnt) begin n_fails++; $display("[TB] FAIL load_use_cnt: got %0d want %0d", bus.zero_lunch_cnt_o, exp_cnt); end
    n_checks++; if (exe_v !== 2'b00) begin n_fails++; $display("[TB] FAIL load_use_bubble: got %b want 00", exe_v); end
    n_checks++; if (flags !== F_DBL) begin n_fails++; $display("[TB] FAIL after_bubble_flags: got %b want %b", flags, F_DBL); end
    step();
    n_checks++; if (exe_v !== 2'b11) begin n_fails++; $display("[TB] FAIL after_bubble_exe: got %b want 11", exe_v); end
    // load in lane 2 feeds the scoreboard's second entry
    set_lane1(1'b1, 5'd10, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'hD1);
    set_lane2(1'b1, 5'd7,  1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 64'hD2);
    #1;
    n_checks++; if (flags !== F_DBL) begin n_fails++; $display("[TB] FAIL load2_launch_flags: got %b want %b", flags, F_DBL); end
    step();
    set_lane1(1'b1, 5'd11, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'hD3);
    set_lane2(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 64'hD4);
    #1;
    n_checks++; if (flags !== F_SGL) begin n_fails++; $display("[TB] FAIL load2_use_flags: got %b want %b", flags, F_SGL); end
    step();
    n_checks++; if (bus.exe_line1_payload_o !== 64'hD3) begin n_fails++; $display("[TB] FAIL load2_use_payload1: got %h want d3", bus.exe_line1_payload_o); end
    set_lane1(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 64'hD4);
    set_lane2(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0);
    #1;
    n_checks++; if (flags !== F_SGL) begin n_fails++; $display("[TB] FAIL load2_clear_flags: got %b want %b", flags, F_SGL); end
    clear_queue();
    step();
  endtask

  task automatic test_solo();
    set_lane1(1'b1, 5'd13, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 64'hE1);
    set_lane2(1'b1, 5'd14, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'hE2);
    #1;
    n_checks++; if (flags !== F_SGL) begin n_fails++; $display("[TB] FAIL solo1_flags: got %b want %b", flags, F_SGL); end
    step();
    set_lane1(1'b1, 5'd14, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'hE2);
    set_lane2(1'b1, 5'd15, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 64'hE3);
    #1;
    n_checks++; if (flags !== F_SGL) begin n_fails++; $display("[TB] FAIL solo2_flags: got %b want %b", flags, F_SGL); end
    step();
    n_checks++; if (exe_v !== 2'b10) begin n_fails++; $display("[TB] FAIL solo2_exe: got %b want 10", exe_v); end
    set_lane1(1'b1, 5'd15, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 64'hE3);
    set_lane2(1'b1, 5'd16, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'hE4);
    #1;
    n_checks++; if (flags !== F_SGL) begin n_fails++; $display("[TB] FAIL solo_alone_flags: got %b want %b", flags, F_SGL); end
    step();
    n_checks++; if (bus.exe_line1_payload_o !== 64'hE3) begin n_fails++; $display("[TB] FAIL solo_alone_payload1: got %h want e3", bus.exe_line1_payload_o); end
    clear_queue();
    step();
  endtask

  task automatic test_stall();
    set_lane1(1'b1, 5'd9, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 64'hF1);
    step();
    set_lane1(1'b1, 5'd16, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'hF2);
    set_lane2(1'b1, 5'd17, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'hF3);
    bus.next_allowin_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (flags !== F_ZRO) begin n_fails++; $display("[TB] FAIL stall_flags[%0d]: got %b want %b", i, flags, F_ZRO); end
      step();
      exp_cnt = exp_cnt + 32'd1;
    end
    n_checks++; if (exe_v !== 2'b10) begin n_fails++; $display("[TB] FAIL stall_exe_hold: got %b want 10", exe_v); end
    n_checks++; if (bus.exe_line1_payload_o !== 64'hF1) begin n_fails++; $display("[TB] FAIL stall_payload_hold: got %h want f1", bus.exe_line1_payload_o); end
    n_checks++; if (bus.zero_lunch_cnt_o !== exp_cnt) begin n_fails++; $display("[TB] FAIL stall_cnt: got %0d want %0d", bus.zero_lunch_cnt_o, exp_cnt); end
    // the load on r9 must still be tracked after the stall
    bus.next_allowin_i = 1'b1;
    set_lane1(1'b1, 5'd16, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'hF2);
    #1;
    n_checks++; if (flags !== F_ZRO) begin n_fails++; $display("[TB] FAIL stall_sb_hold_flags: got %b want %b", flags, F_ZRO); end
    step();
    exp_cnt = exp_cnt + 32'd1;
    n_checks++; if (flags !== F_DBL) begin n_fails++; $display("[TB] FAIL stall_release_flags: got %b want %b", flags, F_DBL); end
    step();
    n_checks++; if (exe_v !== 2'b11) begin n_fails++; $display("[TB] FAIL stall_release_exe: got %b want 11", exe_v); end
    n_checks++; if (bus.zero_lunch_cnt_o !== exp_cnt) begin n_fails++; $display("[TB] FAIL stall_release_cnt: got %0d want %0d", bus.zero_lunch_cnt_o, exp_cnt); end
    clear_queue();
    step();
  endtask

  task automatic test_flush();
    set_lane1(1'b1, 5'd10, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 64'h61);
    set_lane2(1'b1, 5'd11, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 64'h62);
    step();
    n_checks++; if (exe_v !== 2'b11) begin n_fails++; $display("[TB] FAIL flush_pre_exe: got %b want 11", exe_v); end
    set_lane1(1'b1, 5'd18, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'h63);
    set_lane2(1'b1, 5'd19, 1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'h64);
    bus.excep_flush_i = 1'b1;
    #1;
    n_checks++; if (flags !== F_ZRO) begin n_fails++; $display("[TB] FAIL flush_flags: got %b want %b", flags, F_ZRO); end
    step();
    bus.excep_flush_i = 1'b0;
    n_checks++; if (exe_v !== 2'b00) begin n_fails++; $display("[TB] FAIL flush_exe: got %b want 00", exe_v); end
    n_checks++; if (bus.exe_line2_payload_o !== 64'h0) begin n_fails++; $display("[TB] FAIL flush_payload2: got %h want 0", bus.exe_line2_payload_o); end
    n_checks++; if (bus.zero_lunch_cnt_o !== exp_cnt) begin n_fails++; $display("[TB] FAIL flush_cnt: got %0d want %0d", bus.zero_lunch_cnt_o, exp_cnt); end
    #1;
    n_checks++; if (flags !== F_DBL) begin n_fails++; $display("[TB] FAIL flush_sb_empty_flags: got %b want %b", flags, F_DBL); end
    bus.branch_flush_i = 1'b1;
    #1;
    n_checks++; if (flags !== F_ZRO) begin n_fails++; $display("[TB] FAIL branch_flush_flags: got %b want %b", flags, F_ZRO); end
    bus.branch_flush_i = 1'b0;
    step();
    n_checks++; if (bus.exe_line1_payload_o !== 64'h63) begin n_fails++; $display("[TB] FAIL post_flush_payload1: got %h want 63", bus.exe_line1_payload_o); end
    clear_queue();
    step();
  endtask

  task automatic test_line2_only();
    set_lane2(1'b1, 5'd20, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'h71);
    #1;
    n_checks++; if (flags !== F_ZRO) begin n_fails++; $display("[TB] FAIL line2_only_flags: got %b want %b", flags, F_ZRO); end
    step();
    n_checks++; if (bus.zero_lunch_cnt_o !== exp_cnt) begin n_fails++; $display("[TB] FAIL line2_only_cnt: got %0d want %0d", bus.zero_lunch_cnt_o, exp_cnt); end
    n_checks++; if (exe_v !== 2'b00) begin n_fails++; $display("[TB] FAIL line2_only_exe: got %b want 00", exe_v); end
    clear_queue();
  endtask

  task automatic test_reset_mid();
    set_lane1(1'b1, 5'd21, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'h81);
    set_lane2(1'b1, 5'd22, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 64'h82);
    step();
    n_checks++; if (exe_v !== 2'b11) begin n_fails++; $display("[TB] FAIL mid_pre_exe: got %b want 11", exe_v); end
    #2;
    rst_n = 1'b1;
    #1;
    n_checks++; if (exe_v !== 2'b00) begin n_fails++; $display("[TB] FAIL mid_reset_exe: got %b want 00", exe_v); end
    n_checks++; if (bus.exe_line1_payload_o !== 64'h0) begin n_fails++; $display("[TB] FAIL mid_reset_payload1: got %h want 0", bus.exe_line1_payload_o); end
    n_checks++; if (bus.zero_lunch_cnt_o !== 32'd0) begin n_fails++; $display("[TB] FAIL mid_reset_cnt: got %0d want 0", bus.zero_lunch_cnt_o); end
    clear_queue();
    step();
    rst_n = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    exp_cnt  = 32'd0;
    test_reset();
    test_double();
    test_raw_waw();
    test_load_use();
    test_solo();
    test_stall();
    test_flush();
    test_line2_only();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
